// File: rtl/fetch_sequencer_pkg.sv
// Shared front-end types and constants for the fetch sequencer.
// Holds the fetch FSM encoding, the NOP word and core-wide defaults.
package fetch_sequencer_pkg;

    localparam int          FETCH_WIDTH      = 32;
    localparam logic [31:0] FETCH_RESET_ADDR = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        OUT   = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_wait_timer.sv
// Up-counter tracking how long a memory request has gone un-acked.
// expire flags the enabled cycle whose increment reaches MAX_WAIT.
module fetch_wait_timer
    import fetch_sequencer_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    localparam int CW      = $clog2(MAX_WAIT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          enable,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          expire
);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (enable && count != CW'(MAX_WAIT)) begin
            count <= count + CW'(1);
        end
    end

    assign expire = enable && (count == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the pc, runs one memory request at a
// time and hands fetched words to decode, with redirect and timeout.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int               WIDTH      = FETCH_WIDTH,
    parameter logic [WIDTH-1:0] RESET_ADDR = FETCH_RESET_ADDR,
    parameter int               MAX_WAIT   = 15
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_redirect,
    input  logic [WIDTH-1:0] i_redirect_addr,
    output logic             o_mem_req,
    output logic [WIDTH-1:0] o_mem_addr,
    input  logic             i_mem_ack,
    input  logic [WIDTH-1:0] i_mem_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_pc,
    output logic [WIDTH-1:0] o_instr,
    output logic             o_fault
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    fetch_state_t     state;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] target;
    logic             squash;
    logic             in_req;
    logic             expire;

    assign target = {i_redirect_addr[WIDTH-1:2], 2'b00};
    assign in_req = (state == REQ);

    fetch_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk      (i_clock),
        .rst_n    (i_reset),
        .clear    (!in_req || i_mem_ack),
        .enable   (in_req && !i_mem_ack),
        .load     (1'b0),
        .load_val ({CW{1'b0}}),
        .expire   (expire)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state      <= IDLE;
            pc         <= RESET_ADDR;
            squash     <= 1'b0;
            o_mem_req  <= 1'b0;
            o_mem_addr <= RESET_ADDR;
            o_valid    <= 1'b0;
            o_pc       <= '0;
            o_instr    <= WIDTH'(NOP_INSTR);
            o_fault    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state     <= REQ;
                    o_mem_req <= 1'b1;
                    if (i_redirect) begin
                        pc         <= target;
                        o_mem_addr <= target;
                    end else begin
                        o_mem_addr <= pc;
                    end
                end
                REQ: begin
                    if (i_mem_ack) begin
                        if (i_redirect) begin
                            pc         <= target;
                            o_mem_addr <= target;
                            squash     <= 1'b0;
                        end else if (squash) begin
                            squash     <= 1'b0;
                            o_mem_addr <= pc;
                        end else begin
                            o_instr   <= i_mem_data;
                            o_pc      <= pc;
                            pc        <= pc + WIDTH'(4);
                            o_mem_req <= 1'b0;
                            o_valid   <= 1'b1;
                            state     <= OUT;
                        end
                    end else if (expire) begin
                        state     <= FAULT;
                        o_mem_req <= 1'b0;
                        o_fault   <= 1'b1;
                    end else if (i_redirect) begin
                        // address stays on the bus until the old ack
                        pc     <= target;
                        squash <= 1'b1;
                    end
                end
                OUT: begin
                    if (i_ready || i_redirect) begin
                        o_valid   <= 1'b0;
                        o_mem_req <= 1'b1;
                        state     <= REQ;
                        if (i_redirect) begin
                            pc         <= target;
                            o_mem_addr <= target;
                        end else begin
                            o_mem_addr <= pc;
                        end
                    end
                end
                FAULT: begin
                    o_mem_req <= 1'b0;
                    o_valid   <= 1'b0;
                end
                default: state <= FAULT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: handshakes, redirects,
// pc wrap and the un-acked request timeout.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] redir_addr = '0;
    logic        ack = 1'b0;
    logic [31:0] mdata = '0;
    logic        ready = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;

    int checks = 0;
    int errors = 0;

    fetch_sequencer #(
        .WIDTH      (32),
        .RESET_ADDR (32'h0000_0000),
        .MAX_WAIT   (15)
    ) dut (
        .i_clock         (clk),
        .i_reset         (rst_n),
        .i_redirect      (redir),
        .i_redirect_addr (redir_addr),
        .o_mem_req       (mem_req),
        .o_mem_addr      (mem_addr),
        .i_mem_ack       (ack),
        .i_mem_data      (mdata),
        .o_valid         (valid),
        .i_ready         (ready),
        .o_pc            (pc),
        .o_instr         (instr),
        .o_fault         (fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dword(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_req(input string tag, input logic [31:0] addr);
        chk({tag, " req"}, 32'(mem_req), 32'd1);
        chk({tag, " addr"}, mem_addr, addr);
        chk({tag, " valid"}, 32'(valid), 32'd0);
    endtask

    task automatic chk_out(input string tag, input logic [31:0] a);
        chk({tag, " valid"}, 32'(valid), 32'd1);
        chk({tag, " req"}, 32'(mem_req), 32'd0);
        chk({tag, " pc"}, pc, a);
        chk({tag, " instr"}, instr, dword(a));
    endtask

    initial begin
        ready = 1'b1;
        step();
        step();
        chk("rst req", 32'(mem_req), 32'd0);
        chk("rst addr", mem_addr, 32'h0);
        chk("rst valid", 32'(valid), 32'd0);
        chk("rst pc", pc, 32'h0);
        chk("rst instr", instr, 32'h0000_0013);
        chk("rst fault", 32'(fault), 32'd0);

        rst_n = 1'b1;
        #2;
        chk("idle req", 32'(mem_req), 32'd0);
        step();
        chk_req("first", 32'h0);

        // zero-wait memory, decode always ready
        ack = 1'b1; mdata = dword(32'h0);
        step();
        chk_out("o0", 32'h0);
        ack = 1'b0; mdata = '1;
        step();
        chk_req("r4", 32'h4);
        ack = 1'b1; mdata = dword(32'h4);
        step();
        chk_out("o4", 32'h4);
        ack = 1'b0;
        step();
        chk_req("r8", 32'h8);

        // slow memory and stalled decode
        ready = 1'b0;
        step();
        chk_req("r8 w1", 32'h8);
        ack = 1'b1; mdata = dword(32'h8);
        #0;
        step();
        chk_out("o8", 32'h8);
        ack = 1'b0; mdata = '1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("o8 stall", 32'h8);
        end
        ready = 1'b1;
        step();
        chk_req("rC", 32'hC);

        // redirect while the request to 0xC is outstanding
        redir = 1'b1; redir_addr = 32'h100;
        step();
        redir = 1'b0;
        chk_req("sq hold1", 32'hC);
        step();
        chk_req("sq hold2", 32'hC);
        ack = 1'b1; mdata = dword(32'hC);
        step();
        chk_req("sq drop", 32'h100);
        ack = 1'b1; mdata = dword(32'h100);
        step();
        chk_out("o100", 32'h100);
        ack = 1'b0;
        step();
        chk_req("r104", 32'h104);

        // redirect coincident with ack, unaligned target
        ack = 1'b1; mdata = dword(32'h104);
        redir = 1'b1; redir_addr = 32'h203;
        step();
        redir = 1'b0;
        chk_req("ackredir", 32'h200);
        ack = 1'b1; mdata = dword(32'h200);
        step();
        chk_out("o200", 32'h200);
        ack = 1'b0;

        // redirect in the same cycle decode accepts
        ready = 1'b1; redir = 1'b1; redir_addr = 32'h300;
        step();
        redir = 1'b0;
        chk_req("outredir", 32'h300);
        ack = 1'b1; mdata = dword(32'h300);
        step();
        chk_out("o300", 32'h300);
        ack = 1'b0;

        // redirect while decode stalls drops the instruction
        ready = 1'b0; redir = 1'b1; redir_addr = 32'h400;
        step();
        redir = 1'b0; ready = 1'b1;
        chk_req("stallredir", 32'h400);

        // pc wrap from the top word
        ack = 1'b1; mdata = dword(32'h400);
        redir = 1'b1; redir_addr = 32'hFFFF_FFFF;
        step();
        redir = 1'b0;
        chk_req("rtop", 32'hFFFF_FFFC);
        ack = 1'b1; mdata = dword(32'hFFFF_FFFC);
        step();
        chk_out("otop", 32'hFFFF_FFFC);
        ack = 1'b0;
        step();
        chk_req("wrap", 32'h0);

        // memory never acknowledges
        for (int i = 1; i < 15; i++) begin
            step();
            chk("to req", 32'(mem_req), 32'd1);
            chk("to nofault", 32'(fault), 32'd0);
        end
        step();
        chk("to fault", 32'(fault), 32'd1);
        chk("to req off", 32'(mem_req), 32'd0);
        redir = 1'b1; redir_addr = 32'h500; ack = 1'b1;
        step();
        redir = 1'b0; ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold fault", 32'(fault), 32'd1);
            chk("hold req", 32'(mem_req), 32'd0);
            chk("hold valid", 32'(valid), 32'd0);
        end

        rst_n = 1'b0;
        #1;
        chk("clr fault", 32'(fault), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk_req("restart", 32'h0);

        // asynchronous reset mid-request
        rst_n = 1'b0;
        #1;
        chk("async req", 32'(mem_req), 32'd0);
        chk("async addr", mem_addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controller that sequences instruction fetch for the RISC-V front end. Owns the program counter, issues one request at a time to a variable-latency instruction memory over a req/ack handshake, and presents each fetched instruction to decode over a valid/ready handshake. Handles branch redirects, including one arriving while a memory request is outstanding, and detects a memory that never acknowledges.

## Interface
- WIDTH, 32, address and instruction width
- RESET_ADDR, 32'h0000_0000, first fetch address after reset
- MAX_WAIT, 15, cycles a request may stay un-acked before fault (1..255)

- i_clock  in  1  single clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_redirect  in  1  branch/jump taken, one-cycle pulse
- i_redirect_addr  in  WIDTH  redirect target; bits [1:0] are forced to 0
- o_mem_req  out  1  instruction memory request
- o_mem_addr  out  WIDTH  request address, word aligned
- i_mem_ack  in  1  memory acknowledge; data valid in the same cycle
- i_mem_data  in  WIDTH  instruction word returned with ack
- o_valid  out  1  instruction available to decode
- i_ready  in  1  decode accepts the instruction
- o_pc  out  WIDTH  address of o_instr
- o_instr  out  WIDTH  fetched instruction
- o_fault  out  1  sticky fetch timeout flag

## Operation
- States: IDLE, REQ, OUT, FAULT.
- Reset values: state IDLE, pc=RESET_ADDR, o_mem_req=0, o_mem_addr=RESET_ADDR, o_valid=0, o_pc=0, o_instr=NOP (32'h0000_0013), o_fault=0, squash=0, wait counter=0.
- IDLE: spends one cycle, then moves to REQ.
- REQ: o_mem_req=1 and o_mem_addr=pc. The request and its address stay stable until ack.
  - On ack with squash=0: o_instr<=i_mem_data, o_pc<=pc, pc<=pc+4, state moves to OUT.
  - On ack with squash=1: the data is discarded, squash<=0, and the state stays in REQ with the new pc.
- OUT: o_valid=1; o_pc and o_instr are held stable.
  - On i_ready: transfer completes, o_valid drops, state moves to REQ.
- Redirect rules; redirect has priority over the normal pc update:
  - In REQ without ack: pc<=target and squash<=1. The old address stays on o_mem_addr until ack.
  - In REQ with ack in the same cycle: data is discarded, pc<=target, state stays in REQ.
  - In OUT without i_ready: o_valid<=0, the instruction is dropped, pc<=target, state moves to REQ.
  - In OUT with i_ready in the same cycle: the transfer completes, then pc<=target and state moves to REQ.
  - A second redirect during squash overwrites pc; squash stays 1.
  - In IDLE: pc<=target.
  - In FAULT: ignored.
- Timeout:
  - The wait counter increments each REQ cycle without ack and clears on ack or on leaving REQ.
  - When the counter reaches MAX_WAIT: state moves to FAULT, o_mem_req<=0, o_fault<=1.
  - FAULT holds until reset; o_valid=0 in FAULT.
- Arithmetic: pc+4 wraps modulo 2^WIDTH (32'hFFFF_FFFC -> 0).

## Timing
- Reset deassertion at edge N: IDLE during cycle N, first o_mem_req in cycle N+1.
- Zero-wait memory (ack in the first REQ cycle): o_valid rises the next cycle.
- Sustained throughput with zero-wait memory and i_ready=1: one instruction per 2 cycles.
- Redirect to first request on the new path: 1 cycle when no request is outstanding; otherwise the cycle after the pending ack.
- All outputs are registered; no combinational path from i_ready or i_mem_ack to any output.
- Asynchronous reset mid-request drops o_mem_req immediately. The memory must tolerate an abandoned request.

## Structure
- Shared package holds:
  - the state enum (IDLE, REQ, OUT, FAULT)
  - the NOP constant 32'h0000_0013
  - the default RESET_ADDR
  - the WIDTH default, shared with the rest of the core
- One sub-module, fetch_wait_timer: loadable up-counter with clear, enable and terminal-count output, sized by $clog2(MAX_WAIT+1).

## Test plan
- Reset with zero-wait memory, i_ready=1 -> requests at 0x0, 0x4, 0x8; o_valid every other cycle; o_pc matches; first req one cycle after reset release.
- Memory acks after 3 cycles; i_ready held low 4 cycles in OUT -> o_mem_addr stable through the wait; o_pc/o_instr stable while o_valid=1 and i_ready=0; no new request until accepted.
- Redirect to 0x100 while a request to 0x8 is un-acked (ack 2 cycles later) -> 0x8 data never presented; next request 0x100; o_pc=0x100.
- Redirect to 0x203 in the same cycle as ack -> data discarded; next request 0x200.
- Redirect in the same cycle as an OUT-state transfer at 0x10 -> 0x10 consumed by decode; next request at the target.
- No ack with MAX_WAIT=15 -> o_fault=1 after 15 REQ cycles; o_mem_req=0; stays until i_reset low; after release fetch restarts at RESET_ADDR.
- pc=32'hFFFF_FFFC fetched -> next request 0x0.
